// File: rtl/ebpc_stream_arb.sv
// ebpc_stream_arb: merges the ZNZ and BPC encoder streams into one
// valid/ready stream. Grants alternate between the sources, each grant lasting
// up to MAX_BURST beats. A grant also ends early when its source goes idle.
// The merged output is a single registered stage.
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   znz_data_i/znz_vld_i/znz_rdy_o     zero/non-zero input stream
//   bpc_data_i/bpc_vld_i/bpc_rdy_o     bit-plane input stream
//   data_o/src_o/beat_o/vld_o/rdy_i    merged stream: word, source (1 = BPC),
//                                      beat index within the grant, handshake
module ebpc_stream_arb #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_W-1:0]            znz_data_i,
    input  logic                         znz_vld_i,
    output logic                         znz_rdy_o,
    input  logic [DATA_W-1:0]            bpc_data_i,
    input  logic                         bpc_vld_i,
    output logic                         bpc_rdy_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         src_o,
    output logic [$clog2(MAX_BURST)-1:0] beat_o,
    output logic                         vld_o,
    input  logic                         rdy_i
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ZNZ = 2'd1,
        GNT_BPC = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                src_q, src_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic                out_free;
    logic                gnt_src;
    logic                gnt_vld;
    logic [DATA_W-1:0]   gnt_data;

    // State and output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            src_q   <= src_d;
            beat_q  <= beat_d;
        end
    end

    // Arbitration, input ready and output register next-state
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        // Output drains when the sink takes it; otherwise it holds
        vld_d     = vld_q && !rdy_i;
        data_d    = data_q;
        src_d     = src_q;
        beat_d    = beat_q;
        znz_rdy_o = 1'b0;
        bpc_rdy_o = 1'b0;
        out_free  = !vld_q || rdy_i;
        gnt_src   = (state_q == GNT_BPC);
        gnt_vld   = gnt_src ? bpc_vld_i : znz_vld_i;
        gnt_data  = gnt_src ? bpc_data_i : znz_data_i;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prio_q ? bpc_vld_i : znz_vld_i) begin
                    state_d = prio_q ? GNT_BPC : GNT_ZNZ;
                end else if (prio_q ? znz_vld_i : bpc_vld_i) begin
                    state_d = prio_q ? GNT_ZNZ : GNT_BPC;
                end
            end
            GNT_ZNZ, GNT_BPC: begin
                if (gnt_src) bpc_rdy_o = out_free;
                else         znz_rdy_o = out_free;

                if (!gnt_vld) begin
                    // Granted source went idle: hand over immediately
                    state_d = IDLE;
                    prio_d  = !gnt_src;
                end else if (out_free) begin
                    vld_d  = 1'b1;
                    data_d = gnt_data;
                    src_d  = gnt_src;
                    beat_d = cnt_q;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        prio_d  = !gnt_src;
                    end else begin
                        cnt_d = BEAT_W'(cnt_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign src_o  = src_q;
    assign beat_o = beat_q;

endmodule

// File: doc/ebpc_stream_arb.md
EBPC_STREAM_ARB -- requirements
Module: ebpc_stream_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of every data word.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum beats per grant, legal range 2..256.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports znz_data_i  input  DATA_W, znz_vld_i  input  1, znz_rdy_o  output  1: zero/non-zero stream from the encoder.
REQ-006 SHALL have ports bpc_data_i  input  DATA_W, bpc_vld_i  input  1, bpc_rdy_o  output  1: bit-plane stream from the encoder.
REQ-007 SHALL have port data_o  output  DATA_W  merged output word.
REQ-008 SHALL have port src_o  output  1  source of data_o (0 = ZNZ, 1 = BPC).
REQ-009 SHALL have port beat_o  output  clog2(MAX_BURST)  index of the word within its grant, starting at 0.
REQ-010 SHALL have ports vld_o  output  1 and rdy_i  input  1: merged-stream handshake.

Function
REQ-011 Handshakes SHALL be valid/ready: a beat transfers in a cycle where vld and rdy are both high; a source holds data and vld until it transfers.
REQ-012 FSM SHALL have states IDLE, GNT_ZNZ, GNT_BPC, plus a 1-bit priority pointer prio (0 = ZNZ).
REQ-013 In IDLE: if the prio source's vld is high, go to its GNT state; else if the other source's vld is high, go to its GNT state; else stay. No beat is accepted in IDLE.
REQ-014 In a GNT state, only the granted source's rdy SHALL be driven: rdy = out_free, where out_free = !vld_o || rdy_i. The non-granted rdy SHALL be 0.
REQ-015 An accepted beat SHALL be loaded into the output register on the same edge: vld_o=1, data_o=word, src_o=granted source, beat_o=burst counter. Latency input transfer to vld_o is 1 cycle.
REQ-016 Burst counter SHALL reset to 0 on each IDLE->GNT transition and increment per accepted beat.
REQ-017 Accepting beat index MAX_BURST-1 SHALL end the grant: next state IDLE, prio set to the other source.
REQ-018 In a GNT state with granted vld low, the grant SHALL end the same cycle: next state IDLE, prio set to the other source; no beat is accepted.
REQ-019 In a GNT state with granted vld high but out_free low, the FSM SHALL stay; the grant is not ended by back-pressure.
REQ-020 When vld_o && !rdy_i, data_o/src_o/beat_o/vld_o SHALL hold stable.
REQ-021 When the output transfers and no new beat is accepted that cycle, vld_o SHALL go 0 on the next edge.
REQ-022 With both sources continuously valid and rdy_i=1, throughput SHALL be MAX_BURST beats per MAX_BURST+1 cycles, grants strictly alternating.
REQ-023 Word order within each source SHALL be preserved; no word duplicated or dropped.

Reset
REQ-024 While rst_i=1 at an edge: state=IDLE, prio=0, counter=0, vld_o=0, data_o=0, src_o=0, beat_o=0; znz_rdy_o and bpc_rdy_o SHALL be 0 combinationally whenever state is IDLE.
REQ-025 Reset asserted mid-burst SHALL discard the output register content without transferring it; the first grant after release goes to ZNZ if valid.

Verification
REQ-026 MAX_BURST=8, only ZNZ valid with 20 words 0x01..0x14, rdy_i=1 -> output ZNZ bursts beat_o 0..7, 0..7, 0..3, one IDLE cycle between bursts, data in order.
REQ-027 Both sources always valid, rdy_i=1 -> src_o sequence 8x0, 8x1, 8x0, ...; vld_o low exactly one cycle per 9.
REQ-028 ZNZ granted, znz_vld_i drops after 3 beats while BPC valid -> ZNZ beats 0..2, then BPC burst starting beat_o=0; ZNZ later resumes with beat_o=0.
REQ-029 Out stalled (rdy_i=0) for 5 cycles with vld_o=1, data_o=0xA5 -> output fields unchanged, granted rdy low, no input transfer; transfers on first rdy_i=1 cycle.
REQ-030 rst_i pulsed during beat 4 of a BPC burst -> vld_o=0 next cycle, pending word not transferred; after release with both valid, first output src_o=0, beat_o=0.
REQ-031 Random vld/rdy stalls (0..3 cycles) on all three ports, 10k words per source -> per-source output order matches input exactly, beat_o never exceeds 7.
